// File: rtl/row_packer_if.sv
// ============================================================================
// Module      : row_packer_if
// Description : Pixel-in / row-out handshake bundle for row_packer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface row_packer_if #(
    parameter int R = 10,
    parameter int W = 8
) ();
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_data;
    logic           s_last;
    logic           m_valid;
    logic           m_ready;
    logic [R*W-1:0] m_data;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

`default_nettype wire

// File: rtl/row_packer.sv
// ============================================================================
// Module      : row_packer
// Description : Packs a serial signed pixel stream into R-lane rows using two
//               ping-pong banks. Optional ReLU on entry: ROW_PACKER_RELU_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module row_packer #(
    parameter int R = 10,
    parameter int W = 8
) (
    input  wire logic    clk,
    input  wire logic    rstn,
    row_packer_if.slave  bus
);
    localparam int                 c_COL_W    = (R > 1) ? $clog2(R) : 1;
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(R - 1);

    logic [R*W-1:0]   r_bank [2];
    logic [c_COL_W-1:0] r_col;
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_cnt;

    logic             w_s_ready;
    logic             w_m_valid;
    logic             w_s_acc;
    logic             w_m_acc;
    logic             w_close;
    logic [W-1:0]     w_pixel;

    // Readiness depends only on the registered fill count, never on m_ready.
    assign w_s_ready = (r_cnt != 2'd2);
    assign w_m_valid = (r_cnt != 2'd0);
    assign w_s_acc   = bus.s_valid && w_s_ready;
    assign w_m_acc   = w_m_valid && bus.m_ready;
    assign w_close   = w_s_acc && ((r_col == c_LAST_COL) || bus.s_last);

`ifdef ROW_PACKER_RELU_EN
    assign w_pixel = bus.s_data[W-1] ? '0 : bus.s_data;
`else
    assign w_pixel = bus.s_data;
`endif

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = r_bank[r_rd];

    // Lanes above the closing column are zero-filled so short rows are clean.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
        end else if (w_s_acc) begin
            for (int i = 0; i < R; i++) begin
                if (c_COL_W'(i) == r_col) begin
                    r_bank[r_wr][i*W +: W] <= w_pixel;
                end else if (w_close && (c_COL_W'(i) > r_col)) begin
                    r_bank[r_wr][i*W +: W] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col <= '0;
            r_wr  <= 1'b0;
        end else if (w_close) begin
            r_col <= '0;
            r_wr  <= ~r_wr;
        end else if (w_s_acc) begin
            r_col <= r_col + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd <= 1'b0;
        end else if (w_m_acc) begin
            r_rd <= ~r_rd;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= 2'd0;
        end else begin
            case ({w_close, w_m_acc})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_row_packer.sv
// ============================================================================
// Module      : tb_row_packer
// Description : Randomized scoreboard bench for row_packer (R=4, W=8).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_row_packer;
    localparam int R = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    row_packer_if #(.R(R), .W(W)) bus ();

    row_packer #(.R(R), .W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rows_in  = 0;
    int rows_out = 0;
    int mode     = 0;   // m_ready policy: 0 low, 1 high, 2 toggle, 3 random

    logic [R*W-1:0] exp_q [$];
    logic [W-1:0]   part  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_px(input logic [W-1:0] p);
`ifdef ROW_PACKER_RELU_EN
        return ($signed(p) < 0) ? '0 : p;
`else
        return p;
`endif
    endfunction

    // Queue depth is the number of closed rows still owed downstream.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            logic [R*W-1:0] row;
            chk("m_valid", 64'(bus.m_valid), 64'(exp_q.size() != 0));
            chk("s_ready", 64'(bus.s_ready), 64'(exp_q.size() < 2));
            if (bus.m_valid && exp_q.size() > 0)
                chk("m_data", 64'(bus.m_data), 64'(exp_q[0]));
            if (bus.m_valid && bus.m_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                rows_out++;
            end
            if (bus.s_valid && bus.s_ready) begin
                part.push_back(model_px(bus.s_data));
                if (part.size() == R || bus.s_last) begin
                    row = '0;
                    foreach (part[i]) row[i*W +: W] = part[i];
                    exp_q.push_back(row);
                    rows_in++;
                    part.delete();
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            2:       bus.m_ready = ~bus.m_ready;
            default: bus.m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input logic [W-1:0] d, input logic last);
        logic acc;
        int   n;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 64'(n), 64'(0));
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic drain();
        mode = 1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        #1;
        chk("reset_m_valid", 64'(bus.m_valid), 64'(0));
        chk("reset_m_data",  64'(bus.m_data),  64'(0));
        chk("reset_s_ready", 64'(bus.s_ready), 64'(1));
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single full row with downstream always ready.
        mode = 1;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        drain();

        // Backpressure: two rows held, third waits until m_ready rises.
        mode = 0;
        fork
            for (int i = 1; i <= 12; i++) send(8'(i), 1'b0);
        join_none
        repeat (20) @(posedge clk);
        chk("bp_rows_held", 64'(exp_q.size()), 64'(2));
        mode = 1;
        wait fork;
        drain();

        // Short row via s_last, then a full row starting at lane 0.
        send(8'h05, 1'b0);
        send(8'h06, 1'b1);
        for (int i = 1; i <= 4; i++) send(8'(i + 8'h20), 1'b0);
        drain();

        // Sign handling.
        send(8'hF0, 1'b0);
        send(8'h10, 1'b0);
        send(8'h80, 1'b0);
        send(8'h7F, 1'b0);
        drain();

        // s_last on lane 0 and on lane R-1.
        send(8'h81, 1'b1);
        for (int i = 0; i < 4; i++) send(8'($urandom), i == 3);
        drain();

        // Toggling m_ready so closes and accepts coincide.
        mode = 2;
        for (int i = 0; i < 40; i++) send(8'($urandom), 1'($urandom_range(0, 5) == 0));
        send(8'($urandom), 1'b1);
        drain();

        // Random m_ready with random idle gaps.
        mode = 3;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 1'($urandom_range(0, 6) == 0));
        end
        send(8'($urandom), 1'b1);
        drain();

        // Reset with one row pending and two pixels of the next in flight.
        mode = 0;
        for (int i = 1; i <= 4; i++) send(8'(i + 8'h40), 1'b0);
        send(8'h51, 1'b0);
        send(8'h52, 1'b0);
        chk("pre_reset_m_valid", 64'(bus.m_valid), 64'(1));
        #2 rstn = 1'b0;
        #1;
        chk("async_m_valid", 64'(bus.m_valid), 64'(0));
        chk("async_m_data",  64'(bus.m_data),  64'(0));
        chk("async_s_ready", 64'(bus.s_ready), 64'(1));
        rows_in = rows_in - exp_q.size();
        exp_q.delete();
        part.delete();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        mode = 1;
        for (int i = 1; i <= 4; i++) send(8'(i + 8'h60), 1'b0);
        drain();

        chk("rows_delivered", 64'(rows_out), 64'(rows_in));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/row_packer.md
# row_packer

Upstream feeder for the 2x2 max-pool stage. Accepts a serial stream of signed W-bit pixels, one per handshake, and assembles them into R-lane rows. Completed rows are presented on a valid/ready interface that drives the pool stage's `s_valid`/`s_ready`/`s_data` directly. Two row banks (ping-pong) let the input keep filling one row while the finished row waits for the pool stage, and an optional ReLU clamps negative pixels on entry.

## Interface
- `R`, 10, lanes per row; even, ≥2; matches the pool stage `R`.
- `W`, 8, pixel width in bits; matches the pool stage `W`.

- `clk`  input  1  clock; all state on rising edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `s_valid`  input  1  input pixel valid.
- `s_ready`  output  1  input pixel accepted when `s_valid && s_ready`.
- `s_data`  input  W  pixel, two's-complement signed.
- `s_last`  input  1  qualifies the beat as the final pixel of a row; sampled only on an accepted beat.
- `m_valid`  output  1  a complete row is present on `m_data`.
- `m_ready`  input  1  downstream accepts the row when `m_valid && m_ready`.
- `m_data`  output  R×W  packed row; lane 0 = first pixel received.

## Operation
- State:
  - two banks `bank[0:1]` of R×W;
  - write column `col` (`$clog2(R)` bits, 0..R-1);
  - write-bank select `wr`;
  - read-bank select `rd`;
  - full count `cnt` (0..2).
- `s_ready = (cnt != 2)`. This is combinational from registered `cnt` only, with no path from `m_ready`.
- Accepted beat:
  - writes the processed pixel into `bank[wr][col]`.
  - If `col == R-1` or `s_last`, the row closes:
    - all lanes above `col` in `bank[wr]` are zero-filled;
    - `col ← 0`, `wr ← ~wr`, `cnt` increments.
  - Otherwise `col ← col+1`.
- `s_last` on lane R-1 behaves exactly like a normal row close. `s_last` on lane 0 emits a row holding one pixel and R-1 zeros.
- `m_valid = (cnt != 0)` and `m_data = bank[rd]`, both driven from registers.
- Accepted output (`m_valid && m_ready`): `rd ← ~rd` and `cnt` decrements.
- Row close and output accept in the same cycle: `cnt` is unchanged, and both `wr` and `rd` toggle.
- A bank is never written while `cnt` counts it full. The `s_ready` rule guarantees this.
- Pixel processing: see Configuration. Output lanes are unsigned W-bit values as seen by the pool comparator.
- Reset, asynchronous and taking effect immediately:
  - `cnt=0`, `col=0`, `wr=0`, `rd=0`, both banks cleared;
  - so `m_valid=0`, `m_data=0`, `s_ready=1`.
- A partial row in progress at reset is discarded, and no row is emitted for it.

## Timing
- Latency: a row closed by an accepted beat at edge N shows `m_valid=1` with valid `m_data` immediately after edge N. That is a 1-cycle latency, with no combinational input-to-output path.
- Throughput: 1 pixel/cycle sustained while `m_ready` permits. A full row drains in one cycle.
- Backpressure: with `m_ready=0`, the packer absorbs exactly 2 complete rows. `s_ready` then falls in the cycle after the second row closes.
- `s_ready` rises the cycle after an output accept frees a bank.
- `m_data` is stable while `m_valid && !m_ready`.
- Upstream must hold `s_data`/`s_last` stable while `s_valid && !s_ready`. The packer does not check this.

## Configuration
- `ROW_PACKER_RELU_EN`:
  - Defined: each accepted pixel with its sign bit set is written as 0, and non-negative pixels are written unchanged.
  - Undefined: pixels are written bit-for-bit, so negative values appear as large unsigned values downstream.
  - Interface and timing are identical in both builds.

## Test plan
All scenarios use R=4, W=8.
- Reset, then stream 8'h01,02,03,04 with `m_ready=1` → `m_data={04,03,02,01}` and `m_valid` high for one cycle, the cycle after the 4th accept; `s_ready` stays high.
- Stream 12 pixels 1..12 back-to-back with `m_ready=0` → rows {4,3,2,1} and {8,7,6,5} are held, and `s_ready` drops after the 8th accept. Raising `m_ready` then yields row1, row2, row3 in order with no loss.
- Stream 8'h05,06 with `s_last` on 06 → row {00,00,06,05}, and the next row starts at lane 0.
- Stream 8'hF0,10,80,7F:
  - with `ROW_PACKER_RELU_EN` defined → {7F,00,10,00};
  - without → {7F,80,10,F0}.
- Sustained stream with `m_ready` toggling every cycle, making close and accept coincide → every row is delivered exactly once and in order, and `cnt` never exceeds 2.
- Deassert `rstn` after 2 pixels of a row, plus one full row pending → `m_valid`, `m_data` and `s_ready` go to 0, 0 and 1 immediately. The next 4 pixels form a clean row starting at lane 0.
